// File: rtl/count_packer.sv
// Packs consecutive counter nibbles into words, tags words containing a counter
// wrap (max -> 0) and queues them in a show-ahead FIFO behind valid/ready.
module count_packer #(
    parameter int unsigned IN_W  = 4,
    parameter int unsigned LANES = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic [IN_W-1:0]              count,
    output logic [IN_W*LANES-1:0]        out_data,
    output logic                         out_wrap,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   fill_level,
    output logic                         overflow
);

    localparam int unsigned OUT_W = IN_W * LANES;
    localparam int unsigned LOW_W = OUT_W - IN_W;
    localparam int unsigned PTR_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CW    = $clog2(DEPTH + 1);
    localparam int unsigned ENT_W = OUT_W + 1;

    // Packer state: only the lower lanes are stored; the top lane comes from count
    logic [PTR_W-1:0] lane_ptr;
    logic [IN_W-1:0]  prev;
    logic             prev_ok;
    logic             wrap_acc;
    logic [LOW_W-1:0] word_acc;

    // FIFO state
    logic [ENT_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    logic             last_lane;
    logic             wrap_now;
    logic             push_req;
    logic             full;
    logic             pop;
    logic             push;
    logic [ENT_W-1:0] push_entry;
    logic [ENT_W-1:0] head;

    // Handshake decode and word assembly
    always_comb begin
        last_lane  = (lane_ptr == PTR_W'(LANES - 1));
        wrap_now   = in_valid && prev_ok && (prev == '1) && (count == '0);
        push_req   = in_valid && last_lane;
        full       = (fill_level == CW'(DEPTH));
        pop        = out_valid && out_ready;
        push       = push_req && (!full || pop);
        push_entry = {wrap_acc | wrap_now, count, word_acc};
        head       = mem[rd_ptr];
    end

    // Lane pointer, wrap tracking and partial-word storage
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lane_ptr <= '0;
            prev     <= '0;
            prev_ok  <= 1'b0;
            wrap_acc <= 1'b0;
            word_acc <= '0;
        end else if (in_valid) begin
            prev    <= count;
            prev_ok <= 1'b1;
            if (last_lane) begin
                lane_ptr <= '0;
                wrap_acc <= 1'b0;
            end else begin
                lane_ptr <= lane_ptr + PTR_W'(1);
                wrap_acc <= wrap_acc | wrap_now;
                for (int unsigned i = 0; i < LANES - 1; i++) begin
                    if (lane_ptr == PTR_W'(i)) begin
                        word_acc[i*IN_W +: IN_W] <= count;
                    end
                end
            end
        end
    end

    // Storage array; contents are only observable through a non-empty head
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_level <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                fill_level <= fill_level + CW'(1);
            end else if (pop && !push) begin
                fill_level <= fill_level - CW'(1);
            end
            if (push_req && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Head outputs decoded from registered state; zero when empty
    always_comb begin
        out_valid = (fill_level != '0);
        out_data  = out_valid ? head[OUT_W-1:0] : '0;
        out_wrap  = out_valid & head[OUT_W];
    end

endmodule

// File: tb/tb_count_packer.sv
// Directed self-checking bench for count_packer: packing, wrap tagging,
// overflow, full push/pop, gapped input and asynchronous reset.
module tb_count_packer;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [3:0]  count;
    logic [15:0] out_data;
    logic        out_wrap;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  fill_level;
    logic        overflow;

    int tests_run;
    int tests_failed;

    count_packer #(.IN_W(4), .LANES(4), .DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .count      (count),
        .out_data   (out_data),
        .out_wrap   (out_wrap),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fill_level (fill_level),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        in_valid  = 1'b0;
        count     = 4'h0;
        out_ready = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic feed(input logic [3:0] v);
        in_valid = 1'b1;
        count    = v;
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        in_valid = 1'b0;
        count = 4'h0;
        out_ready = 1'b0;
        step();
        tests_run++;
        if (out_data !== 16'h0) begin tests_failed++; $display("FAIL reset_out_data: got %h expected 0000", out_data); end
        tests_run++;
        if (out_valid !== 1'b0 || out_wrap !== 1'b0) begin tests_failed++; $display("FAIL reset_valid_wrap: got %b%b expected 00", out_valid, out_wrap); end
        tests_run++;
        if (fill_level !== 3'd0 || overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_fill_ovf: got %0d/%b expected 0/0", fill_level, overflow); end
        reset = 1'b1;
        step();
    endtask

    task automatic test_basic();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            count = 4'(i);
            step();
            if (i == 2) begin
                tests_run++;
                if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_early_valid: got %b expected 0", out_valid); end
            end
            if (i == 3) begin
                tests_run++;
                if (out_valid !== 1'b1 || out_data !== 16'h3210 || out_wrap !== 1'b0) begin
                    tests_failed++; $display("FAIL basic_word0: got v=%b d=%h w=%b expected v=1 d=3210 w=0", out_valid, out_data, out_wrap);
                end
            end
            if (i == 4) begin
                tests_run++;
                if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_pop: got valid %b expected 0", out_valid); end
            end
            if (i == 7) begin
                tests_run++;
                if (out_valid !== 1'b1 || out_data !== 16'h7654 || out_wrap !== 1'b0) begin
                    tests_failed++; $display("FAIL basic_word1: got v=%b d=%h w=%b expected v=1 d=7654 w=0", out_valid, out_data, out_wrap);
                end
            end
        end
        in_valid = 1'b0;
        step();
        tests_run++;
        if (out_valid !== 1'b0 || fill_level !== 3'd0) begin tests_failed++; $display("FAIL basic_drain: got v=%b fill=%0d expected 0/0", out_valid, fill_level); end
        out_ready = 1'b0;
    endtask

    task automatic test_wrap();
        logic [3:0]  seq [8];
        logic [15:0] exp_w [5];
        seq = '{4'hC, 4'hD, 4'hE, 4'hF, 4'h0, 4'h1, 4'h2, 4'h3};
        do_reset();
        for (int i = 0; i < 8; i++) feed(seq[i]);
        tests_run++;
        if (fill_level !== 3'd2 || out_data !== 16'hFEDC || out_wrap !== 1'b0) begin
            tests_failed++; $display("FAIL wrap_head0: got fill=%0d d=%h w=%b expected 2 FEDC 0", fill_level, out_data, out_wrap);
        end
        out_ready = 1'b1;
        step();
        tests_run++;
        if (out_data !== 16'h3210 || out_wrap !== 1'b1) begin
            tests_failed++; $display("FAIL wrap_head1: got d=%h w=%b expected 3210 1", out_data, out_wrap);
        end
        step();
        out_ready = 1'b0;

        // Continuous counter: the 5th word wraps only via its lane-0 compare
        exp_w = '{16'h3210, 16'h7654, 16'hBA98, 16'hFEDC, 16'h3210};
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            count = 4'(i);
            step();
            if (i % 4 == 3) begin
                tests_run++;
                if (out_valid !== 1'b1 || out_data !== exp_w[i/4] || out_wrap !== (i == 19)) begin
                    tests_failed++; $display("FAIL wrap_cont_word%0d: got v=%b d=%h w=%b expected v=1 d=%h w=%b",
                                             i/4, out_valid, out_data, out_wrap, exp_w[i/4], (i == 19));
                end
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_overflow();
        logic [15:0] exp_w [4];
        exp_w = '{16'h3210, 16'h7654, 16'hBA98, 16'hFEDC};
        do_reset();
        for (int i = 0; i < 24; i++) begin
            feed(4'(i));
            if (i == 15) begin
                tests_run++;
                if (fill_level !== 3'd4 || overflow !== 1'b0) begin tests_failed++; $display("FAIL ovf_full: got fill=%0d ovf=%b expected 4/0", fill_level, overflow); end
            end
        end
        tests_run++;
        if (fill_level !== 3'd4 || overflow !== 1'b1 || out_data !== 16'h3210) begin
            tests_failed++; $display("FAIL ovf_set: got fill=%0d ovf=%b d=%h expected 4/1/3210", fill_level, overflow, out_data);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tests_run++;
            if (out_valid !== 1'b1 || out_data !== exp_w[k] || out_wrap !== 1'b0) begin
                tests_failed++; $display("FAIL ovf_drain%0d: got v=%b d=%h w=%b expected v=1 d=%h w=0", k, out_valid, out_data, out_wrap, exp_w[k]);
            end
            step();
        end
        tests_run++;
        if (out_valid !== 1'b0 || fill_level !== 3'd0 || overflow !== 1'b1) begin
            tests_failed++; $display("FAIL ovf_empty: got v=%b fill=%0d ovf=%b expected 0/0/1", out_valid, fill_level, overflow);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_full_pushpop();
        logic [15:0] exp_w [4];
        exp_w = '{16'h7654, 16'hBA98, 16'hFEDC, 16'h3210};
        do_reset();
        for (int i = 0; i < 19; i++) feed(4'(i));
        out_ready = 1'b1;
        feed(4'h3);
        out_ready = 1'b0;
        tests_run++;
        if (fill_level !== 3'd4 || overflow !== 1'b0 || out_data !== 16'h7654) begin
            tests_failed++; $display("FAIL full_pushpop: got fill=%0d ovf=%b d=%h expected 4/0/7654", fill_level, overflow, out_data);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tests_run++;
            if (out_valid !== 1'b1 || out_data !== exp_w[k] || out_wrap !== (k == 3)) begin
                tests_failed++; $display("FAIL full_order%0d: got v=%b d=%h w=%b expected v=1 d=%h w=%b", k, out_valid, out_data, out_wrap, exp_w[k], (k == 3));
            end
            step();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_gapped();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            feed(4'(5 + i));
            if (i < 3) begin
                step();
                step();
                tests_run++;
                if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL gap_valid%0d: got %b expected 0", i, out_valid); end
            end
        end
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 16'h8765 || out_wrap !== 1'b0 || fill_level !== 3'd1) begin
            tests_failed++; $display("FAIL gap_word: got v=%b d=%h w=%b fill=%0d expected 1 8765 0 1", out_valid, out_data, out_wrap, fill_level);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 8; i++) feed(4'(i));
        feed(4'hE);
        feed(4'hF);
        #2;
        reset = 1'b0;
        #1;
        tests_run++;
        if (out_data !== 16'h0 || out_wrap !== 1'b0 || out_valid !== 1'b0 || fill_level !== 3'd0 || overflow !== 1'b0) begin
            tests_failed++; $display("FAIL rst_async: got d=%h w=%b v=%b fill=%0d ovf=%b expected all 0", out_data, out_wrap, out_valid, fill_level, overflow);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        feed(4'h8); feed(4'h9); feed(4'hA); feed(4'hB);
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 16'hBA98 || out_wrap !== 1'b0 || fill_level !== 3'd1) begin
            tests_failed++; $display("FAIL rst_fresh_word: got v=%b d=%h w=%b fill=%0d expected 1 BA98 0 1", out_valid, out_data, out_wrap, fill_level);
        end

        // prev=F before reset must not tag a post-reset leading 0
        do_reset();
        feed(4'hF);
        reset = 1'b0;
        step();
        reset = 1'b1;
        feed(4'h0); feed(4'h1); feed(4'h2); feed(4'h3);
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 16'h3210 || out_wrap !== 1'b0) begin
            tests_failed++; $display("FAIL rst_no_false_wrap: got v=%b d=%h w=%b expected 1 3210 0", out_valid, out_data, out_wrap);
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        reset = 1'b0;
        in_valid = 1'b0;
        count = 4'h0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_wrap();
        test_overflow();
        test_full_pushpop();
        test_gapped();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/count_packer.md
# count_packer

Downstream consumer of the 4-bit free-running counter stage. Accepts one `count` nibble per qualified cycle and packs four consecutive nibbles into a 16-bit word. Tags each word when the counter wrapped (4'hF -> 4'h0) inside it. Buffers words in a small show-ahead FIFO behind a valid/ready output handshake, so a slower sink can drain counter history without stalling the counter.

## Interface

- `IN_W`, 4, width of one counter sample (nibble)
- `LANES`, 4, samples per output word; `OUT_W = IN_W*LANES` = 16
- `DEPTH`, 4, FIFO depth in words (power of two, >= 2)

- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-low; 0 clears all state immediately; release is synchronous to `clk`
- `in_valid`  in  1  `count` is a sample to accept this cycle
- `count`  in  IN_W  counter value from the upstream counter
- `out_data`  out  OUT_W  FIFO head word; lane 0 (first sample) in bits [3:0]
- `out_wrap`  out  1  head word contains a wrap
- `out_valid`  out  1  FIFO non-empty
- `out_ready`  in  1  sink accepts head word this cycle
- `fill_level`  out  $clog2(DEPTH+1)  words currently stored
- `overflow`  out  1  sticky: at least one completed word was dropped

## Operation

- **Accept:** a sample is accepted on any edge with `in_valid`=1. There is no input backpressure; `count` is never stalled.
- **Lane pointer:** a 2-bit pointer selects the lane slot for each accepted sample and increments on each accept. It wraps 3->0, and that wrap marks word completion.
- **Wrap detect:**
  - `prev` holds the last accepted sample.
  - `prev_ok` is set by the first accept after reset.
  - A wrap is detected on an accept when `prev_ok`=1, `prev`==4'hF and `count`==4'h0.
  - The word's wrap bit is the OR over its 4 accepts. This includes lane 0, which is compared against the previous word's lane 3.
- **Push:** on the edge that accepts lane 3, {wrap, assembled word with the current sample in [15:12]} is written to the FIFO, provided it is not full. The wrap accumulator clears for the next word.
- **Pop:** occurs on an edge with `out_valid`=1 and `out_ready`=1; the head advances. `out_ready` while empty is ignored.
- **Full-FIFO rules:**
  - Push while full with no pop in the same cycle: the word is dropped, `overflow` is set (sticky until reset), and FIFO contents are unchanged.
  - Push and pop in the same cycle while full: both succeed, there is no drop, and `fill_level` stays at DEPTH.
  - Push and pop in the same cycle while empty: impossible, because the head is empty.
- **Ordering:** words leave in completion order; there is no reordering.
- **Partial words:** a partial word (fewer than 4 accepts) is held indefinitely while `in_valid`=0. It is never flushed except by reset.
- **Reset (any time, including mid-word or mid-pop):**
  - Pointer 0, `prev_ok` 0, wrap accumulator 0, FIFO empty.
  - Outputs: `out_data` 0, `out_wrap` 0, `out_valid` 0, `fill_level` 0, `overflow` 0.
  - The partial word is discarded.

## Timing

- **Latency:** the 4th accepting edge at cycle N gives `out_valid`=1 with the word on `out_data` after edge N (visible in cycle N+1).
- **Show-ahead head:** `out_data`/`out_wrap` are stable while `out_valid`=1 and `out_ready`=0.
- **Counter update:** `fill_level` changes on the edge of push/pop; it is +1, -1 or 0 when both occur.
- **Throughput:** one word per 4 cycles sustained with `in_valid`=1 and `out_ready`=1. The FIFO never fills under that load.
- **Registered outputs:** all outputs are registered or decoded from registered state; there is no combinational path from `in_valid`/`count` to any output.

## Test plan

- **Basic packing:** after reset release, feed 0..7 on consecutive cycles with `out_ready`=1 -> words 16'h3210 (`out_wrap` 0) then 16'h7654. `out_valid` rises the cycle after sample 3 is accepted.
- **Wrap tagging:** feed C,D,E,F,0,1,2,3 -> 16'hFEDC with `out_wrap` 0, then 16'h3210 with `out_wrap` 1. Also feed a continuous counter 0..F,0..3 -> the 5th word has `out_wrap` 1 from the lane-0 boundary compare.
- **Overflow:** hold `out_ready`=0 and feed 24 samples (6 words):
  - `fill_level` = 4 and `overflow` = 1; words 5 and 6 are dropped.
  - Release `out_ready` -> the first 4 words drain in order, then `out_valid` = 0 and `fill_level` = 0.
- **Full with simultaneous push/pop:** fill to 4, then assert `out_ready` on the edge that completes a 5th word -> no drop, `overflow` stays 0, `fill_level` stays 4.
- **Gapped input:** `in_valid` toggles 1,0,0,1,... across 4 samples -> one correct word. The partial word is held during gaps, and `out_valid` stays 0 until lane 3 is accepted.
- **Reset mid-operation:** accept 2 samples with 2 words queued, pull `reset` low -> all outputs are 0 immediately. After release, feed 8,9,A,B -> 16'hBA98 with `out_wrap` 0: there is no stale lane and no false wrap against pre-reset `prev`.
